sigpulse_burst_ctrl: RTL and testbench
======================================

// Module: sigpulse_burst_ctrl
// PURPOSE
//  Sequencer for one sigpulse instance: on a start request, fires a burst of N single pulses
//  through sigpulse's one-cycle trigger, with a programmable idle gap between pulses.
//  Tracks completion on sigpulse's pulse_valid and aborts through pwm_dis on a stop request.
//  Sits between the register/host side and sigpulse; it is sigpulse's sole driver.
// PARAMETERS
//  _RAM_WIDTH  32  width of the pulse-width word passed to sigpulse
//  CNT_W       16  width of the burst pulse count and the completed-pulse counter
//  GAP_W       32  width of the inter-pulse gap, in io_clk cycles
//  DIS_CYCLES  2   cycles pwm_dis is held high on abort (>=1)
// PORTS
//  io_clk           in   1           system clock
//  io_rst           in   1           reset: synchronous, active-high
//  start            in   1           one-cycle burst request
//  stop             in   1           one-cycle abort request
//  cfg_pulseWidth   in   _RAM_WIDTH  pulse width for every pulse in the burst
//  cfg_defaultLevel in   1           idle level forwarded to sigpulse
//  cfg_count        in   CNT_W       pulses per burst
//  cfg_gap          in   GAP_W       cycles from a done edge to the next trigger
//  sp_en            out  1           sigpulse io_en: exactly one cycle per pulse
//  sp_dis           out  1           sigpulse pwm_dis
//  sp_pulseWidth    out  _RAM_WIDTH  sigpulse io_pulseWidth (latched copy)
//  sp_defaultLevel  out  1           sigpulse io_defaultLevel (latched copy)
//  sp_valid         in   1           sigpulse pulse_valid; a rising edge means the pulse completed
//  busy             out  1           high in every state except IDLE
//  done             out  1           one-cycle pulse when a burst ends (normal end or abort)
//  aborted          out  1           set when a burst ends by stop; cleared at the next accepted start
//  pulse_cnt        out  CNT_W       pulses completed in the current or last burst
// BEHAVIOUR
//  Reset values:
//   - All outputs 0 on reset, including sp_pulseWidth and sp_defaultLevel.
//   - State returns to IDLE at the next edge.
//   - Reset mid-burst does not assert sp_dis.
//  States: IDLE, FIRE, WAIT_DONE, GAP, ABORT, FINISH.
//  IDLE:
//   - start && !stop && cfg_count!=0 -> FIRE.
//   - On entry to FIRE: latch all cfg_* inputs, clear pulse_cnt and aborted.
//   - start with cfg_count==0 is ignored: no done.
//   - start && stop in the same cycle is ignored.
//   - stop alone is ignored.
//  FIRE: sp_en=1 for this one cycle -> WAIT_DONE.
//   - Latency: start sampled at edge k gives sp_en high from edge k+1 to edge k+2.
//  WAIT_DONE:
//   - Edge detect: sp_valid && !sp_valid_d, where sp_valid_d is registered and updated every cycle.
//   - Edge detected: pulse_cnt+1; if the new count == latched count -> FINISH, else -> GAP.
//   - GAP loads its down-counter with the latched gap.
//   - No timeout; a hung sigpulse is cleared by stop.
//  GAP:
//   - Count down; at zero -> FIRE.
//   - A done edge sampled at edge m gives the next sp_en at edge m+1+gap.
//   - gap=0 gives back-to-back triggering at m+1.
//  FINISH: done=1 for one cycle -> IDLE.
//  stop in FIRE, WAIT_DONE or GAP:
//   - -> ABORT. sp_dis=1 for DIS_CYCLES cycles starting at the next edge.
//   - Then done=1 and aborted=1 -> IDLE.
//   - stop has priority over a simultaneous done edge; pulse_cnt is not incremented.
//   - stop arriving in the same cycle as sp_en: sp_en still completes its one cycle.
//  start while busy is ignored. stop in ABORT or FINISH is ignored.
//  sp_dis=0 outside ABORT. sp_en=0 outside FIRE.
//  cfg_* changes during a burst have no effect until the next accepted start.
//  pulse_cnt holds after the burst ends; it never wraps, because cfg_count <= 2^CNT_W-1.
// TESTING
//  1. count=3, gap=5, width=100; sigpulse model raises valid 100 cycles after sp_en
//     -> 3 single-cycle sp_en, 106 cycles apart; done once; pulse_cnt=3; aborted=0.
//  2. count=2, gap=0 -> second sp_en exactly 1 cycle after the first done edge; done after the 2nd edge.
//  3. count=4; stop mid-WAIT_DONE of pulse 2
//     -> sp_dis high for 2 cycles; done and aborted=1; pulse_cnt=1; no further sp_en.
//  4. start while busy, start with count=0, and start+stop in the same cycle in IDLE
//     -> each ignored: no extra sp_en, no done.
//  5. Change cfg_pulseWidth from 100 to 7 mid-burst -> sp_pulseWidth stays 100 until the next start.
//  6. io_rst asserted during GAP -> next edge: IDLE; all outputs 0; sp_dis never pulsed.

Source files
------------

// File: rtl/sigpulse_burst_ctrl_if.sv
// sigpulse_burst_ctrl_if
//  Groups the host-side request/config signals and the sigpulse-side drive/status
//  signals of one burst controller.
//  slave  : the burst controller (consumes requests and config, drives sigpulse and status)
//  master : the host / register side together with the sigpulse instance
//  Signals:
//   start, stop                 one-cycle burst request / abort request
//   cfg_pulseWidth              pulse width for every pulse in a burst
//   cfg_defaultLevel            idle level forwarded to sigpulse
//   cfg_count                   pulses per burst
//   cfg_gap                     cycles from a done edge to the next trigger
//   sp_en, sp_dis               sigpulse trigger and pwm disable
//   sp_pulseWidth               latched pulse width towards sigpulse
//   sp_defaultLevel             latched idle level towards sigpulse
//   sp_valid                    sigpulse pulse_valid
//   busy, done, aborted         burst status
//   pulse_cnt                   pulses completed in the current or last burst
interface sigpulse_burst_ctrl_if #(
    parameter int unsigned _RAM_WIDTH = 32,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned GAP_W      = 32
);
    logic                  start;
    logic                  stop;
    logic [_RAM_WIDTH-1:0] cfg_pulseWidth;
    logic                  cfg_defaultLevel;
    logic [CNT_W-1:0]      cfg_count;
    logic [GAP_W-1:0]      cfg_gap;

    logic                  sp_en;
    logic                  sp_dis;
    logic [_RAM_WIDTH-1:0] sp_pulseWidth;
    logic                  sp_defaultLevel;
    logic                  sp_valid;

    logic                  busy;
    logic                  done;
    logic                  aborted;
    logic [CNT_W-1:0]      pulse_cnt;

    // Controller side
    modport slave (
        input  start, stop, cfg_pulseWidth, cfg_defaultLevel, cfg_count, cfg_gap, sp_valid,
        output sp_en, sp_dis, sp_pulseWidth, sp_defaultLevel, busy, done, aborted, pulse_cnt
    );

    // Host / sigpulse side
    modport master (
        output start, stop, cfg_pulseWidth, cfg_defaultLevel, cfg_count, cfg_gap, sp_valid,
        input  sp_en, sp_dis, sp_pulseWidth, sp_defaultLevel, busy, done, aborted, pulse_cnt
    );
endinterface : sigpulse_burst_ctrl_if

// File: rtl/sigpulse_burst_ctrl.sv
// sigpulse_burst_ctrl
//  Sequencer for one sigpulse instance. On an accepted start it latches the burst
//  configuration and fires cfg_count single-cycle triggers on sp_en, waiting for a
//  rising edge of sp_valid after each one and then an idle gap of cfg_gap cycles.
//  A stop during the burst holds sp_dis high for DIS_CYCLES cycles and ends the burst
//  as aborted. It is sigpulse's only driver.
//  Ports:
//   io_clk   in   system clock
//   io_rst   in   synchronous active-high reset
//   bus      slave modport of sigpulse_burst_ctrl_if (requests, config, sigpulse drive, status)
module sigpulse_burst_ctrl #(
    parameter int unsigned _RAM_WIDTH = 32,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned GAP_W      = 32,
    parameter int unsigned DIS_CYCLES = 2
) (
    input  logic                  io_clk,
    input  logic                  io_rst,
    sigpulse_burst_ctrl_if.slave  bus
);

    localparam int unsigned DIS_W = (DIS_CYCLES < 1) ? 1 : $clog2(DIS_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FIRE      = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_GAP       = 3'd3,
        S_ABORT     = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    state_t                r_state;

    // Registered outputs
    logic                  r_sp_en;
    logic                  r_sp_dis;
    logic [_RAM_WIDTH-1:0] r_sp_pulse_width;
    logic                  r_sp_default_level;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_aborted;
    logic [CNT_W-1:0]      r_pulse_cnt;

    // Latched burst configuration and working counters
    logic [CNT_W-1:0]      r_count;
    logic [GAP_W-1:0]      r_gap;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [DIS_W-1:0]      r_dis_cnt;
    logic                  r_sp_valid_d;

    logic                  w_start_ok;
    logic                  w_valid_rise;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_gap_zero;

    // Accepted start: not combined with stop and not an empty burst
    assign w_start_ok   = bus.start && !bus.stop && (bus.cfg_count != '0);
    // Completion of a pulse is the rising edge of pulse_valid
    assign w_valid_rise = bus.sp_valid && !r_sp_valid_d;
    assign w_cnt_inc    = r_pulse_cnt + CNT_W'(1);
    assign w_gap_zero   = (r_gap == '0);

    // Burst sequencer
    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            r_state            <= S_IDLE;
            r_sp_en            <= 1'b0;
            r_sp_dis           <= 1'b0;
            r_sp_pulse_width   <= '0;
            r_sp_default_level <= 1'b0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_aborted          <= 1'b0;
            r_pulse_cnt        <= '0;
            r_count            <= '0;
            r_gap              <= '0;
            r_gap_cnt          <= '0;
            r_dis_cnt          <= '0;
            r_sp_valid_d       <= 1'b0;
        end else begin
            r_sp_valid_d <= bus.sp_valid;
            r_sp_en      <= 1'b0;
            r_sp_dis     <= 1'b0;
            r_done       <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_sp_pulse_width   <= bus.cfg_pulseWidth;
                        r_sp_default_level <= bus.cfg_defaultLevel;
                        r_count            <= bus.cfg_count;
                        r_gap              <= bus.cfg_gap;
                        r_pulse_cnt        <= '0;
                        r_aborted          <= 1'b0;
                        r_busy             <= 1'b1;
                        r_state            <= S_FIRE;
                    end
                end

                S_FIRE: begin
                    if (bus.stop) begin
                        r_dis_cnt <= '0;
                        r_state   <= S_ABORT;
                    end else begin
                        r_sp_en <= 1'b1;
                        r_state <= S_WAIT_DONE;
                    end
                end

                S_WAIT_DONE: begin
                    // stop wins over a simultaneous completion edge
                    if (bus.stop) begin
                        r_dis_cnt <= '0;
                        r_state   <= S_ABORT;
                    end else if (w_valid_rise) begin
                        r_pulse_cnt <= w_cnt_inc;
                        if (w_cnt_inc == r_count) begin
                            r_state <= S_FINISH;
                        end else if (w_gap_zero) begin
                            r_state <= S_FIRE;
                        end else begin
                            r_gap_cnt <= r_gap;
                            r_state   <= S_GAP;
                        end
                    end
                end

                S_GAP: begin
                    // Leaving on count 1 lines the trigger up gap cycles after the FIRE a zero gap would take
                    if (bus.stop) begin
                        r_dis_cnt <= '0;
                        r_state   <= S_ABORT;
                    end else if (r_gap_cnt == GAP_W'(1)) begin
                        r_state <= S_FIRE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end

                S_ABORT: begin
                    // sp_dis is held for DIS_CYCLES edges, then the burst closes as aborted
                    if (r_dis_cnt == DIS_W'(DIS_CYCLES)) begin
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_sp_dis  <= 1'b1;
                        r_dis_cnt <= r_dis_cnt + DIS_W'(1);
                    end
                end

                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sp_en           = r_sp_en;
    assign bus.sp_dis          = r_sp_dis;
    assign bus.sp_pulseWidth   = r_sp_pulse_width;
    assign bus.sp_defaultLevel = r_sp_default_level;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.aborted         = r_aborted;
    assign bus.pulse_cnt       = r_pulse_cnt;

    // Trigger and disable are never asserted together
    a_en_dis_excl: assert property (@(posedge io_clk) disable iff (io_rst) !(r_sp_en && r_sp_dis));
    // Each trigger lasts a single cycle
    a_en_single: assert property (@(posedge io_clk) disable iff (io_rst) r_sp_en |=> !r_sp_en);

endmodule : sigpulse_burst_ctrl

// File: tb/tb_sigpulse_burst_ctrl.sv
// tb_sigpulse_burst_ctrl
//  Bench for sigpulse_burst_ctrl. A behavioural sigpulse raises pulse_valid a fixed
//  latency after each trigger; expected trigger, disable and done cycles are queued as
//  stimulus is driven and popped by a negedge monitor when the design produces them.
module tb_sigpulse_burst_ctrl;

    localparam int unsigned RW  = 32;
    localparam int unsigned CW  = 16;
    localparam int unsigned GW  = 32;
    localparam int unsigned DIS = 2;
    localparam int          LAT = 100;

    typedef struct {
        int at;
        int cnt;
        bit ab;
    } done_t;

    logic io_clk = 1'b0;
    logic io_rst;
    always #5 io_clk = ~io_clk;

    sigpulse_burst_ctrl_if #(._RAM_WIDTH(RW), .CNT_W(CW), .GAP_W(GW)) ifc ();

    sigpulse_burst_ctrl #(._RAM_WIDTH(RW), .CNT_W(CW), .GAP_W(GW), .DIS_CYCLES(DIS)) dut (
        .io_clk (io_clk),
        .io_rst (io_rst),
        .bus    (ifc.slave)
    );

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    int    exp_en_q[$];
    int    exp_dis_q[$];
    done_t exp_done_q[$];
    int    en_log[$];

    // Expected-burst model state
    int m_count;
    int m_gap;
    int m_pulses;
    bit m_live = 1'b0;

    int    mon_e;
    done_t mon_d;
    int    md_m;

    always @(posedge io_clk) cyc <= cyc + 1;

    // sigpulse model: pulse_valid rises so that its edge is sampled LAT edges after sp_en rose
    initial begin
        ifc.sp_valid = 1'b0;
        forever begin
            @(negedge io_clk);
            if (ifc.sp_en === 1'b1) begin
                repeat (LAT - 1) @(posedge io_clk);
                #1;
                ifc.sp_valid = 1'b1;
                md_m = cyc + 1;
                if (m_live) begin
                    m_pulses++;
                    if (m_pulses == m_count) begin
                        exp_done_q.push_back('{md_m + 1, m_pulses, 1'b0});
                        m_live = 1'b0;
                    end else begin
                        exp_en_q.push_back(md_m + 1 + m_gap);
                    end
                end
                repeat (2) @(posedge io_clk);
                #1;
                ifc.sp_valid = 1'b0;
            end
        end
    end

    // Scoreboard monitor
    always @(negedge io_clk) begin
        if (ifc.sp_en === 1'b1) begin
            en_log.push_back(cyc);
            checks++;
            if (exp_en_q.size() == 0) begin
                errors++;
                $display("FAIL sp_en_unexpected: sp_en high at cycle %0d, required low", cyc);
            end else begin
                mon_e = exp_en_q.pop_front();
                if (mon_e != cyc) begin
                    errors++;
                    $display("FAIL sp_en_timing: sp_en at cycle %0d, required cycle %0d", cyc, mon_e);
                end
            end
        end
        if (ifc.sp_dis === 1'b1) begin
            checks++;
            if (exp_dis_q.size() == 0) begin
                errors++;
                $display("FAIL sp_dis_unexpected: sp_dis high at cycle %0d, required low", cyc);
            end else begin
                mon_e = exp_dis_q.pop_front();
                if (mon_e != cyc) begin
                    errors++;
                    $display("FAIL sp_dis_timing: sp_dis at cycle %0d, required cycle %0d", cyc, mon_e);
                end
            end
        end
        if (ifc.done === 1'b1) begin
            checks++;
            if (exp_done_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: done high at cycle %0d, required low", cyc);
            end else begin
                mon_d = exp_done_q.pop_front();
                if (mon_d.at != cyc || ifc.pulse_cnt !== CW'(mon_d.cnt) || ifc.aborted !== mon_d.ab) begin
                    errors++;
                    $display("FAIL done_event: cycle=%0d cnt=%0d aborted=%0b, required cycle=%0d cnt=%0d aborted=%0b",
                             cyc, ifc.pulse_cnt, ifc.aborted, mon_d.at, mon_d.cnt, mon_d.ab);
                end
            end
        end
    end

    // Drive a one-cycle start (optionally with stop); queue the first trigger when it should be accepted
    task automatic drive_start(input int cnt, input int gap, input int width, input bit lvl,
                               input bit accept, input bit with_stop);
        ifc.cfg_count        = CW'(cnt);
        ifc.cfg_gap          = GW'(gap);
        ifc.cfg_pulseWidth   = RW'(width);
        ifc.cfg_defaultLevel = lvl;
        ifc.start            = 1'b1;
        ifc.stop             = with_stop;
        if (accept) begin
            m_count  = cnt;
            m_gap    = gap;
            m_pulses = 0;
            m_live   = 1'b1;
            exp_en_q.push_back(cyc + 2);
        end
        @(posedge io_clk);
        #1;
        ifc.start = 1'b0;
        ifc.stop  = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge io_clk);
            #1;
            if (ifc.busy === 1'b0 && exp_en_q.size() == 0 && exp_done_q.size() == 0 && exp_dis_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            exp_en_q.delete();
            exp_done_q.delete();
            exp_dis_q.delete();
            m_live = 1'b0;
        end
    endtask

    task automatic wait_en(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge io_clk);
            #1;
            if (en_log.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        io_rst = 1'b1;
        repeat (3) @(posedge io_clk);
        #1;
        checks++;
        if ({ifc.busy, ifc.sp_en, ifc.sp_dis, ifc.done, ifc.aborted, ifc.sp_defaultLevel} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: busy/en/dis/done/aborted/level=%b, required 000000",
                     {ifc.busy, ifc.sp_en, ifc.sp_dis, ifc.done, ifc.aborted, ifc.sp_defaultLevel});
        end
        checks++;
        if (ifc.pulse_cnt !== '0 || ifc.sp_pulseWidth !== '0) begin
            errors++;
            $display("FAIL reset_values: pulse_cnt=%0d width=%0d, required 0 0", ifc.pulse_cnt, ifc.sp_pulseWidth);
        end
        io_rst = 1'b0;
        repeat (2) @(posedge io_clk);
        #1;
    endtask

    task automatic test_burst_gap5();
        int base;
        bit ok;
        base = en_log.size();
        drive_start(3, 5, 100, 1'b1, 1'b1, 1'b0);
        wait_idle(600, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL burst3_timeout: busy=%0b, required 0", ifc.busy); end
        checks++;
        if (en_log.size() != base + 3) begin
            errors++;
            $display("FAIL burst3_en_count: %0d triggers, required 3", en_log.size() - base);
        end else begin
            checks++;
            if (en_log[base+1] - en_log[base] != 106 || en_log[base+2] - en_log[base+1] != 106) begin
                errors++;
                $display("FAIL burst3_spacing: %0d and %0d cycles, required 106 and 106",
                         en_log[base+1] - en_log[base], en_log[base+2] - en_log[base+1]);
            end
        end
        checks++;
        if (ifc.pulse_cnt !== CW'(3) || ifc.aborted !== 1'b0) begin
            errors++;
            $display("FAIL burst3_status: pulse_cnt=%0d aborted=%0b, required 3 0", ifc.pulse_cnt, ifc.aborted);
        end
        checks++;
        if (ifc.sp_pulseWidth !== RW'(100) || ifc.sp_defaultLevel !== 1'b1) begin
            errors++;
            $display("FAIL burst3_latch: width=%0d level=%0b, required 100 1", ifc.sp_pulseWidth, ifc.sp_defaultLevel);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        bit ok;
        base = en_log.size();
        drive_start(2, 0, 20, 1'b0, 1'b1, 1'b0);
        wait_idle(400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_timeout: busy=%0b, required 0", ifc.busy); end
        checks++;
        if (en_log.size() != base + 2) begin
            errors++;
            $display("FAIL b2b_en_count: %0d triggers, required 2", en_log.size() - base);
        end else begin
            checks++;
            if (en_log[base+1] - en_log[base] != LAT + 1) begin
                errors++;
                $display("FAIL b2b_spacing: %0d cycles, required %0d", en_log[base+1] - en_log[base], LAT + 1);
            end
        end
        checks++;
        if (ifc.pulse_cnt !== CW'(2)) begin
            errors++;
            $display("FAIL b2b_pulse_cnt: %0d, required 2", ifc.pulse_cnt);
        end
    endtask

    task automatic test_abort();
        int base;
        int s;
        bit ok;
        base = en_log.size();
        drive_start(4, 3, 30, 1'b0, 1'b1, 1'b0);
        wait_en(base + 2, 400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_second_en: %0d triggers, required 2", en_log.size() - base); end
        repeat (20) @(posedge io_clk);
        #1;
        s = cyc + 1;
        m_live = 1'b0;
        exp_dis_q.push_back(s + 1);
        exp_dis_q.push_back(s + 2);
        exp_done_q.push_back('{s + 3, 1, 1'b1});
        ifc.stop = 1'b1;
        @(posedge io_clk);
        #1;
        ifc.stop = 1'b0;
        wait_idle(50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_timeout: busy=%0b, required 0", ifc.busy); end
        checks++;
        if (ifc.pulse_cnt !== CW'(1) || ifc.aborted !== 1'b1 || ifc.sp_dis !== 1'b0) begin
            errors++;
            $display("FAIL abort_status: pulse_cnt=%0d aborted=%0b dis=%0b, required 1 1 0",
                     ifc.pulse_cnt, ifc.aborted, ifc.sp_dis);
        end
        repeat (150) @(posedge io_clk);
        #1;
        checks++;
        if (en_log.size() != base + 2) begin
            errors++;
            $display("FAIL abort_no_more_en: %0d triggers, required 2", en_log.size() - base);
        end
    endtask

    task automatic test_ignored_starts();
        int base;
        bit ok;
        base = en_log.size();
        ifc.stop = 1'b1;
        @(posedge io_clk);
        #1;
        ifc.stop = 1'b0;
        drive_start(0, 1, 50, 1'b1, 1'b0, 1'b0);
        drive_start(2, 1, 50, 1'b1, 1'b0, 1'b1);
        repeat (10) @(posedge io_clk);
        #1;
        checks++;
        if (ifc.busy !== 1'b0 || en_log.size() != base) begin
            errors++;
            $display("FAIL ignored_idle: busy=%0b triggers=%0d, required 0 0", ifc.busy, en_log.size() - base);
        end
        checks++;
        if (ifc.aborted !== 1'b1 || ifc.pulse_cnt !== CW'(1) || ifc.sp_pulseWidth !== RW'(30)) begin
            errors++;
            $display("FAIL ignored_hold: aborted=%0b pulse_cnt=%0d width=%0d, required 1 1 30",
                     ifc.aborted, ifc.pulse_cnt, ifc.sp_pulseWidth);
        end
        drive_start(1, 0, 60, 1'b1, 1'b1, 1'b0);
        checks++;
        if (ifc.aborted !== 1'b0 || ifc.pulse_cnt !== '0 || ifc.busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_clear: aborted=%0b pulse_cnt=%0d busy=%0b, required 0 0 1",
                     ifc.aborted, ifc.pulse_cnt, ifc.busy);
        end
        repeat (5) @(posedge io_clk);
        #1;
        drive_start(5, 0, 60, 1'b1, 1'b0, 1'b0);
        wait_idle(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL busy_start_timeout: busy=%0b, required 0", ifc.busy); end
        checks++;
        if (ifc.pulse_cnt !== CW'(1) || en_log.size() != base + 1) begin
            errors++;
            $display("FAIL busy_start_ignored: pulse_cnt=%0d triggers=%0d, required 1 1",
                     ifc.pulse_cnt, en_log.size() - base);
        end
    endtask

    task automatic test_cfg_change();
        int base;
        bit ok;
        base = en_log.size();
        drive_start(2, 2, 100, 1'b0, 1'b1, 1'b0);
        wait_en(base + 1, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL cfg_first_en: %0d triggers, required 1", en_log.size() - base); end
        ifc.cfg_pulseWidth   = RW'(7);
        ifc.cfg_count        = CW'(9);
        ifc.cfg_gap          = GW'(40);
        ifc.cfg_defaultLevel = 1'b1;
        repeat (3) @(posedge io_clk);
        #1;
        checks++;
        if (ifc.sp_pulseWidth !== RW'(100) || ifc.sp_defaultLevel !== 1'b0) begin
            errors++;
            $display("FAIL cfg_mid_burst: width=%0d level=%0b, required 100 0", ifc.sp_pulseWidth, ifc.sp_defaultLevel);
        end
        wait_idle(400, ok);
        checks++;
        if (!ok || ifc.pulse_cnt !== CW'(2) || ifc.sp_pulseWidth !== RW'(100)) begin
            errors++;
            $display("FAIL cfg_burst_end: idle=%0b pulse_cnt=%0d width=%0d, required 1 2 100",
                     ok, ifc.pulse_cnt, ifc.sp_pulseWidth);
        end
        drive_start(1, 0, 7, 1'b1, 1'b1, 1'b0);
        checks++;
        if (ifc.sp_pulseWidth !== RW'(7) || ifc.sp_defaultLevel !== 1'b1) begin
            errors++;
            $display("FAIL cfg_next_start: width=%0d level=%0b, required 7 1", ifc.sp_pulseWidth, ifc.sp_defaultLevel);
        end
        wait_idle(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL cfg_second_timeout: busy=%0b, required 0", ifc.busy); end
    endtask

    task automatic test_reset_in_gap();
        int base;
        bit ok;
        base = en_log.size();
        drive_start(3, 50, 55, 1'b1, 1'b1, 1'b0);
        wait_en(base + 1, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_first_en: %0d triggers, required 1", en_log.size() - base); end
        repeat (105) @(posedge io_clk);
        #1;
        checks++;
        if (ifc.busy !== 1'b1 || ifc.pulse_cnt !== CW'(1)) begin
            errors++;
            $display("FAIL rst_pre_gap: busy=%0b pulse_cnt=%0d, required 1 1", ifc.busy, ifc.pulse_cnt);
        end
        m_live = 1'b0;
        exp_en_q.delete();
        io_rst = 1'b1;
        @(posedge io_clk);
        #1;
        checks++;
        if ({ifc.busy, ifc.sp_en, ifc.sp_dis, ifc.done, ifc.aborted, ifc.sp_defaultLevel} !== 6'b0 ||
            ifc.pulse_cnt !== '0 || ifc.sp_pulseWidth !== '0) begin
            errors++;
            $display("FAIL rst_gap_outputs: flags=%b pulse_cnt=%0d width=%0d, required 000000 0 0",
                     {ifc.busy, ifc.sp_en, ifc.sp_dis, ifc.done, ifc.aborted, ifc.sp_defaultLevel},
                     ifc.pulse_cnt, ifc.sp_pulseWidth);
        end
        io_rst = 1'b0;
        repeat (150) @(posedge io_clk);
        #1;
        checks++;
        if (ifc.busy !== 1'b0 || en_log.size() != base + 1) begin
            errors++;
            $display("FAIL rst_gap_quiet: busy=%0b triggers=%0d, required 0 1", ifc.busy, en_log.size() - base);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        io_rst               = 1'b1;
        ifc.start            = 1'b0;
        ifc.stop             = 1'b0;
        ifc.cfg_pulseWidth   = '0;
        ifc.cfg_defaultLevel = 1'b0;
        ifc.cfg_count        = '0;
        ifc.cfg_gap          = '0;

        test_reset();
        test_burst_gap5();
        test_back_to_back();
        test_abort();
        test_ignored_starts();
        test_cfg_change();
        test_reset_in_gap();

        checks++;
        if (exp_en_q.size() != 0 || exp_dis_q.size() != 0 || exp_done_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: en=%0d dis=%0d done=%0d pending, required 0 0 0",
                     exp_en_q.size(), exp_dis_q.size(), exp_done_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sigpulse_burst_ctrl
